// File: rtl/reg_dump_unit_if.sv
// Beat stream from the register dump engine to the debug/trace link.
interface reg_dump_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, out_addr, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/reg_dump_unit.sv
// Walks x0..x(NUM_REGS-1) through a spare RF read port and streams (addr,data) beats, one per 2 cycles;
// stalls in SEND while out_ready is low. REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  reg_dump_unit_if.master   dump,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              final_idx;
  logic              accept;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_beat_q, csum_beat_d;
`endif

  assign final_idx = (idx_q == ADDR_W'(NUM_REGS - 1));
  assign accept    = (state_q == SEND) && dump.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
    csum_beat_d = csum_beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d      = '0;
          csum_beat_d = 1'b0;
`endif
        end
      end
      READ: begin
        addr_d  = idx_q;
        data_d  = rf_data;
        state_d = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
        csum_d  = csum_q ^ rf_data;
`else
        last_d  = final_idx;
`endif
      end
      SEND: begin
        if (accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
          if (csum_beat_q) begin
            state_d = FIN;
          end else if (final_idx) begin
            // Checksum beat reuses SEND directly; there is no register to read.
            addr_d      = '0;
            data_d      = csum_q;
            last_d      = 1'b1;
            csum_beat_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
`else
          if (final_idx) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
`endif
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
      csum_beat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_beat_q <= csum_beat_d;
`endif
    end
  end

  assign rf_addr        = (state_q == READ) ? idx_q : '0;
  assign dump.out_valid = (state_q == SEND);
  assign dump.out_addr  = addr_q;
  assign dump.out_data  = data_q;
  assign dump.out_last  = last_q;
  assign busy           = (state_q != IDLE);
  // An abort landing in FIN suppresses the pulse.
  assign done           = (state_q == FIN) && !abort;

endmodule
